// File: rtl/axi_sram_bridge.sv
// AXI4 slave bridging a 64-bit master port onto a single-port synchronous SRAM.
// One transaction at a time; FIXED/INCR/WRAP bursts; alternating read/write priority.
module axi_sram_bridge #(
  parameter int unsigned MEM_AW = 16,
  parameter logic [31:0] BASE   = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  // AW channel
  input  logic [3:0]        S_awid,
  input  logic [31:0]       S_awaddr,
  input  logic [7:0]        S_awlen,
  input  logic [2:0]        S_awsize,
  input  logic [1:0]        S_awburst,
  input  logic              S_awvalid,
  output logic              S_awready,
  // W channel
  input  logic [63:0]       S_wdata,
  input  logic [7:0]        S_wstrb,
  input  logic              S_wlast,
  input  logic              S_wvalid,
  output logic              S_wready,
  // B channel
  output logic [3:0]        S_bid,
  output logic [1:0]        S_bresp,
  output logic              S_bvalid,
  input  logic              S_bready,
  // AR channel
  input  logic [3:0]        S_arid,
  input  logic [31:0]       S_araddr,
  input  logic [7:0]        S_arlen,
  input  logic [2:0]        S_arsize,
  input  logic [1:0]        S_arburst,
  input  logic              S_arvalid,
  output logic              S_arready,
  // R channel
  output logic [3:0]        S_rid,
  output logic [63:0]       S_rdata,
  output logic [1:0]        S_rresp,
  output logic              S_rlast,
  output logic              S_rvalid,
  input  logic              S_rready,
  // SRAM port
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned WinLo = MEM_AW + 3;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StWResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;     // 0: read has priority, 1: write has priority
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        werr_q, werr_d;
  logic        rerr_q, rerr_d;
  logic        rvalid_q, rvalid_d;
  logic        issue_q, issue_d;    // first read beat still to be issued
  logic [31:0] addr_nxt;
  logic        beat_last;
  logic        unused_wlast;

  assign unused_wlast = S_wlast;

  function automatic logic in_win(input logic [31:0] a);
    return a[31:WinLo] == BASE[31:WinLo];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] incr;
    logic        wrap_ok;
    step    = 32'd1 << size;
    mask    = ((32'(len) + 32'd1) << size) - 32'd1;
    incr    = (a & ~(step - 32'd1)) + step;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      2'b00:   return a;
      2'b10:   return wrap_ok ? ((a & ~mask) | ((a + step) & mask)) : incr;
      default: return incr;
    endcase
  endfunction

  assign addr_nxt  = next_addr(addr_q, size_q, len_q, burst_q);
  assign beat_last = (cnt_q == len_q);

  assign S_rid     = id_q;
  assign S_rvalid  = rvalid_q;
  assign S_rdata   = rerr_q ? 64'd0 : mem_rdata;
  assign S_rresp   = rerr_q ? 2'b11 : 2'b00;
  assign S_rlast   = beat_last;
  assign S_bid     = id_q;
  assign S_bresp   = werr_q ? 2'b11 : 2'b00;
  assign mem_wdata = S_wdata;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    werr_d    = werr_q;
    rerr_d    = rerr_q;
    rvalid_d  = rvalid_q;
    issue_d   = issue_q;
    S_arready = 1'b0;
    S_awready = 1'b0;
    S_wready  = 1'b0;
    S_bvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 8'h00;
    mem_addr  = addr_q[WinLo-1:3];

    case (state_q)
      StIdle: begin
        S_arready = !prio_q || !S_awvalid;
        S_awready = prio_q || !S_arvalid;
        if (S_arvalid && S_arready) begin
          id_d    = S_arid;
          addr_d  = S_araddr;
          len_d   = S_arlen;
          size_d  = S_arsize;
          burst_d = S_arburst;
          cnt_d   = 8'd0;
          prio_d  = 1'b1;
          issue_d = 1'b1;
          state_d = StRd;
        end else if (S_awvalid && S_awready) begin
          id_d    = S_awid;
          addr_d  = S_awaddr;
          len_d   = S_awlen;
          size_d  = S_awsize;
          burst_d = S_awburst;
          cnt_d   = 8'd0;
          werr_d  = 1'b0;
          prio_d  = 1'b0;
          state_d = StWr;
        end
      end
      StRd: begin
        if (issue_q) begin
          mem_en   = in_win(addr_q);
          rerr_d   = !in_win(addr_q);
          rvalid_d = 1'b1;
          issue_d  = 1'b0;
        end else if (rvalid_q && S_rready) begin
          if (beat_last) begin
            rvalid_d = 1'b0;
            state_d  = StIdle;
          end else begin
            // Next beat is issued in the same cycle its predecessor completes.
            mem_en   = in_win(addr_nxt);
            mem_addr = addr_nxt[WinLo-1:3];
            rerr_d   = !in_win(addr_nxt);
            addr_d   = addr_nxt;
            cnt_d    = cnt_q + 8'd1;
          end
        end
      end
      StWr: begin
        S_wready = 1'b1;
        if (S_wvalid) begin
          mem_en = 1'b1;
          mem_we = in_win(addr_q) ? S_wstrb : 8'h00;
          werr_d = werr_q | !in_win(addr_q);
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) state_d = StWResp;
        end
      end
      StWResp: begin
        S_bvalid = 1'b1;
        if (S_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      id_q     <= 4'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
      cnt_q    <= 8'd0;
      werr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      werr_q   <= werr_d;
      rerr_q   <= rerr_d;
      rvalid_q <= rvalid_d;
      issue_q  <= issue_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Scoreboard bench for axi_sram_bridge: directed scenarios plus random bursts
// checked against a burst-address/memory reference model.
module tb_axi_sram_bridge;

  localparam int unsigned MEM_AW = 16;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clock, reset;
  logic [3:0]  S_awid, S_arid, S_bid, S_rid;
  logic [31:0] S_awaddr, S_araddr;
  logic [7:0]  S_awlen, S_arlen, S_wstrb;
  logic [2:0]  S_awsize, S_arsize;
  logic [1:0]  S_awburst, S_arburst, S_bresp, S_rresp;
  logic        S_awvalid, S_awready, S_wlast, S_wvalid, S_wready;
  logic        S_bvalid, S_bready, S_arvalid, S_arready;
  logic        S_rlast, S_rvalid, S_rready;
  logic [63:0] S_wdata, S_rdata;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  axi_sram_bridge #(.MEM_AW(MEM_AW), .BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .S_awid(S_awid), .S_awaddr(S_awaddr), .S_awlen(S_awlen), .S_awsize(S_awsize),
    .S_awburst(S_awburst), .S_awvalid(S_awvalid), .S_awready(S_awready),
    .S_wdata(S_wdata), .S_wstrb(S_wstrb), .S_wlast(S_wlast), .S_wvalid(S_wvalid),
    .S_wready(S_wready),
    .S_bid(S_bid), .S_bresp(S_bresp), .S_bvalid(S_bvalid), .S_bready(S_bready),
    .S_arid(S_arid), .S_araddr(S_araddr), .S_arlen(S_arlen), .S_arsize(S_arsize),
    .S_arburst(S_arburst), .S_arvalid(S_arvalid), .S_arready(S_arready),
    .S_rid(S_rid), .S_rdata(S_rdata), .S_rresp(S_rresp), .S_rlast(S_rlast),
    .S_rvalid(S_rvalid), .S_rready(S_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {logic [15:0] addr; logic [7:0] we; logic [63:0] wdata;} m_exp_t;
  typedef struct packed {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

  m_exp_t m_q[$];
  r_exp_t r_q[$];
  b_exp_t b_q[$];

  int checks = 0;
  int errors = 0;
  int r_beats = 0;
  int bp_mode = 0;

  logic [63:0] sram    [65536] = '{default: 64'h0};
  logic [63:0] ref_mem [65536] = '{default: 64'h0};
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr;
  logic [63:0] pl_data;

  // Behavioural SRAM: read data appears the cycle after a read enable and is held.
  always @(posedge clock) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    if (mem_en) begin
      if (mem_we == 8'h00) mem_rdata <= sram[mem_addr];
      else for (int b = 0; b < 8; b++)
        if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a >> (MEM_AW + 3)) == (BASE >> (MEM_AW + 3));
  endfunction

  // Address of beat i, computed directly from the burst rules rather than iterated.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
    logic [31:0] sb, total, lower;
    sb    = 32'd1 << size;
    total = (32'(len) + 32'd1) * sb;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      lower = a & ~(total - 32'd1);
      return lower + ((a - lower + 32'(i) * sb) % total);
    end
    if (i == 0) return a;
    return (a & ~(sb - 32'd1)) + 32'(i) * sb;
  endfunction

  function automatic void exp_read(input logic [3:0] id, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [31:0] a;
    logic [15:0] w;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      w = 16'(a >> 3);
      if (in_win(a)) begin
        m_q.push_back('{w, 8'h00, 64'h0});
        r_q.push_back('{id, ref_mem[w], 2'b00, i == int'(len)});
      end else begin
        r_q.push_back('{id, 64'h0, 2'b11, i == int'(len)});
      end
    end
  endfunction

  function automatic void exp_write(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [31:0] a;
    logic [15:0] w;
    logic        err;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      w = 16'(a >> 3);
      if (in_win(a)) begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) ref_mem[w][b*8 +: 8] = wd[i][b*8 +: 8];
        m_q.push_back('{w, ws[i], wd[i]});
      end else begin
        err = 1'b1;
        m_q.push_back('{w, 8'h00, wd[i]});
      end
    end
    b_q.push_back('{id, err ? 2'b11 : 2'b00});
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_en) begin
        if (m_q.size() == 0) note_fail("mem_unexpected");
        else begin
          m_exp_t me;
          me = m_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(me.addr));
          check("mem_we", 64'(mem_we), 64'(me.we));
          if (me.we != 8'h00) check("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (prev_stall && S_rvalid) check("r_stall_hold", S_rdata, prev_data);
      prev_stall = S_rvalid && !S_rready;
      prev_data  = S_rdata;
      if (S_rvalid && S_rready) begin
        r_beats++;
        if (r_q.size() == 0) note_fail("r_unexpected");
        else begin
          r_exp_t re;
          re = r_q.pop_front();
          check("rdata", S_rdata, re.data);
          check("rid", 64'(S_rid), 64'(re.id));
          check("rresp", 64'(S_rresp), 64'(re.resp));
          check("rlast", 64'(S_rlast), 64'(re.last));
        end
      end
      if (S_bvalid && S_bready) begin
        if (b_q.size() == 0) note_fail("b_unexpected");
        else begin
          b_exp_t be;
          be = b_q.pop_front();
          check("bid", 64'(S_bid), 64'(be.id));
          check("bresp", 64'(S_bresp), 64'(be.resp));
        end
      end
    end
  end

  // Response-channel backpressure generator.
  initial begin
    S_rready = 1'b1;
    S_bready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (bp_mode)
        0: begin S_rready = 1'b1; S_bready = 1'b1; end
        1: begin S_rready = ($urandom % 4) != 0; S_bready = 1'($urandom); end
        default: begin S_rready = ~S_rready; S_bready = 1'b1; end
      endcase
    end
  end

  task automatic preload(input logic [15:0] w, input logic [63:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = w; pl_data = d;
    ref_mem[w] = d;
    @(posedge clock);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    @(posedge clock);
    #1;
    S_arid = id; S_araddr = addr; S_arlen = len; S_arsize = size; S_arburst = burst;
    S_arvalid = 1'b1;
    repeat (200) begin
      @(negedge clock);
      if (S_arready) begin ok = 1; break; end
    end
    if (!ok) note_fail("ar_timeout");
    else @(posedge clock);
    #1 S_arvalid = 1'b0;
  endtask

  task automatic issue_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    @(posedge clock);
    #1;
    S_awid = id; S_awaddr = addr; S_awlen = len; S_awsize = size; S_awburst = burst;
    S_awvalid = 1'b1;
    repeat (200) begin
      @(negedge clock);
      if (S_awready) begin ok = 1; break; end
    end
    if (!ok) note_fail("aw_timeout");
    else @(posedge clock);
    #1 S_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len, input bit gaps);
    bit ok;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom % 3) begin
        S_wvalid = 1'b0;
        @(posedge clock);
        #1;
      end
      S_wvalid = 1'b1; S_wdata = wd[i]; S_wstrb = ws[i]; S_wlast = (i == int'(len));
      ok = 0;
      repeat (200) begin
        @(negedge clock);
        if (S_wready) begin ok = 1; break; end
      end
      if (!ok) begin note_fail("w_timeout"); break; end
      @(posedge clock);
      #1;
    end
    S_wvalid = 1'b0;
    S_wlast  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    repeat (3000) begin
      @(negedge clock);
      if (m_q.size() == 0 && r_q.size() == 0 && b_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      note_fail("drain_timeout");
      m_q.delete(); r_q.delete(); b_q.delete();
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    int          start;
    bit          ok;

    reset = 1'b0;
    S_awvalid = 1'b0; S_wvalid = 1'b0; S_arvalid = 1'b0; S_wlast = 1'b0;
    S_awid = '0; S_awaddr = '0; S_awlen = '0; S_awsize = '0; S_awburst = '0;
    S_arid = '0; S_araddr = '0; S_arlen = '0; S_arsize = '0; S_arburst = '0;
    S_wdata = '0; S_wstrb = '0;

    #22;
    check("rst_rvalid", 64'(S_rvalid), 64'd0);
    check("rst_bvalid", 64'(S_bvalid), 64'd0);
    check("rst_wready", 64'(S_wready), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_arready", 64'(S_arready), 64'd1);
    check("rst_awready", 64'(S_awready), 64'd1);
    @(posedge clock);
    #2 reset = 1'b1;

    // Simultaneous AR and AW: read wins first, write follows.
    @(posedge clock);
    #1;
    exp_read(4'h1, BASE + 32'h40, 8'd1, 3'd3, 2'b01);
    wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
    wd[1] = 64'hDEAD_BEEF_0000_0002; ws[1] = 8'hF0;
    exp_write(4'h2, BASE + 32'h80, 8'd1, 3'd3, 2'b01);
    S_arid = 4'h1; S_araddr = BASE + 32'h40; S_arlen = 8'd1; S_arsize = 3'd3; S_arburst = 2'b01;
    S_awid = 4'h2; S_awaddr = BASE + 32'h80; S_awlen = 8'd1; S_awsize = 3'd3; S_awburst = 2'b01;
    S_arvalid = 1'b1;
    S_awvalid = 1'b1;
    @(negedge clock);
    check("arb_arready", 64'(S_arready), 64'd1);
    check("arb_awready", 64'(S_awready), 64'd0);
    @(posedge clock);
    #1 S_arvalid = 1'b0;
    @(negedge clock);
    check("arb_aw_blocked", 64'(S_awready), 64'd0);
    ok = 0;
    repeat (200) begin
      @(negedge clock);
      if (S_awready) begin ok = 1; break; end
    end
    check("arb_aw_granted", 64'(ok), 64'd1);
    @(posedge clock);
    #1 S_awvalid = 1'b0;
    send_w(8'd1, 1'b0);
    wait_idle();

    // Single read with latency checks.
    preload(16'h0000, 64'h1122_3344_5566_7788);
    exp_read(4'd5, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
    issue_ar(4'd5, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
    @(negedge clock);
    check("lat_mem_en_t1", 64'(mem_en), 64'd1);
    check("lat_rvalid_t1", 64'(S_rvalid), 64'd0);
    @(negedge clock);
    check("lat_rvalid_t2", 64'(S_rvalid), 64'd1);
    wait_idle();

    // INCR write with partial strobes, then read back.
    for (int i = 0; i < 4; i++) begin
      preload(16'h0020 + 16'(i), 64'hA5A5_5A5A_0000_0000 | 64'(i + 16));
      wd[i] = 64'(i + 1);
      ws[i] = (i == 0) ? 8'hFF : 8'h0F;
    end
    exp_write(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
    issue_aw(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
    send_w(8'd3, 1'b0);
    wait_idle();
    exp_read(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
    issue_ar(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
    wait_idle();

    // WRAP read.
    exp_read(4'd7, 32'h8000_0018, 8'd3, 3'd3, 2'b10);
    issue_ar(4'd7, 32'h8000_0018, 8'd3, 3'd3, 2'b10);
    wait_idle();

    // Out-of-window write and read.
    wd[0] = 64'h1; ws[0] = 8'hFF;
    wd[1] = 64'h2; ws[1] = 8'hFF;
    exp_write(4'd9, 32'h0000_0000, 8'd1, 3'd3, 2'b01);
    issue_aw(4'd9, 32'h0000_0000, 8'd1, 3'd3, 2'b01);
    send_w(8'd1, 1'b0);
    wait_idle();
    exp_read(4'd9, 32'h0000_0000, 8'd0, 3'd3, 2'b01);
    issue_ar(4'd9, 32'h0000_0000, 8'd0, 3'd3, 2'b01);
    wait_idle();

    // Toggled rready during a len 7 read.
    bp_mode = 2;
    exp_read(4'd4, 32'h8000_0100, 8'd7, 3'd3, 2'b01);
    issue_ar(4'd4, 32'h8000_0100, 8'd7, 3'd3, 2'b01);
    wait_idle();
    bp_mode = 0;

    // Reset during beat 2 of a len 7 read.
    start = r_beats;
    exp_read(4'd6, 32'h8000_0200, 8'd7, 3'd3, 2'b01);
    issue_ar(4'd6, 32'h8000_0200, 8'd7, 3'd3, 2'b01);
    ok = 0;
    repeat (100) begin
      @(negedge clock);
      if (r_beats >= start + 2) begin ok = 1; break; end
    end
    if (!ok) note_fail("rst_mid_wait");
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(S_rvalid), 64'd0);
    check("rst_mid_mem_en", 64'(mem_en), 64'd0);
    m_q.delete(); r_q.delete(); b_q.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    exp_read(4'd8, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
    issue_ar(4'd8, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
    wait_idle();

    // Random traffic with random backpressure.
    bp_mode = 1;
    for (int t = 0; t < 40; t++) begin
      id    = 4'($urandom);
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom);
      case ($urandom % 6)
        0: len = 8'd0;
        1: len = 8'd1;
        2: len = 8'd3;
        3: len = 8'd7;
        4: len = 8'd15;
        default: len = 8'($urandom_range(0, 31));
      endcase
      if ($urandom % 8 == 0) addr = 32'($urandom_range(0, 4095));
      else addr = BASE + 32'($urandom_range(0, 65536 * 8 - 4096));
      if ($urandom % 2 == 0) begin
        exp_read(id, addr, len, size, burst);
        issue_ar(id, addr, len, size, burst);
      end else begin
        for (int i = 0; i <= int'(len); i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = 8'($urandom);
        end
        exp_write(id, addr, len, size, burst);
        issue_aw(id, addr, len, size, burst);
        send_w(len, 1'b1);
      end
      wait_idle();
    end
    bp_mode = 0;
    repeat (4) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_bridge.md
# axi_sram_bridge

AXI4 slave that terminates the core's 64-bit `MAXI_*` master port and drives a single-port synchronous SRAM. It serves as the simulation and FPGA main memory behind `top_axi_wrapper`. It handles one transaction at a time, supports FIXED, INCR and WRAP bursts of up to 256 beats, and uses alternating read/write arbitration. Addresses outside its window receive DECERR.

## Interface
Parameters:
- `MEM_AW`, default 16: SRAM word-address width; capacity is 2^MEM_AW × 8 bytes.
- `BASE`, default 32'h8000_0000: window base; bits [31:MEM_AW+3] are compared.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in, 1: sole clock, rising edge.
  - `reset` in, 1: asynchronous, active-low.
- AW channel:
  - `S_awid`/`S_awaddr`/`S_awlen`/`S_awsize`/`S_awburst` in, 4/32/8/3/2: write address.
  - `S_awvalid` in, 1; `S_awready` out, 1.
- W channel:
  - `S_wdata` in, 64; `S_wstrb` in, 8; `S_wlast` in, 1.
  - `S_wvalid` in, 1; `S_wready` out, 1.
- B channel:
  - `S_bid` out, 4; `S_bresp` out, 2.
  - `S_bvalid` out, 1; `S_bready` in, 1.
- AR channel:
  - `S_arid`/`S_araddr`/`S_arlen`/`S_arsize`/`S_arburst` in, 4/32/8/3/2: read address.
  - `S_arvalid` in, 1; `S_arready` out, 1.
- R channel:
  - `S_rid` out, 4; `S_rdata` out, 64; `S_rresp` out, 2; `S_rlast` out, 1.
  - `S_rvalid` out, 1; `S_rready` in, 1.
- SRAM port:
  - `mem_en` out, 1; `mem_we` out, 8 (byte write enables; 0 means read).
  - `mem_addr` out, MEM_AW; `mem_wdata` out, 64.
  - `mem_rdata` in, 64: valid the cycle after a read `mem_en` and held until the next `mem_en`.

## Operation
- States: IDLE, RD, WR, WRESP.
- Arbitration in IDLE:
  - `S_arready = IDLE && (prio==RD || !S_awvalid)`.
  - `S_awready = IDLE && (prio==WR || !S_arvalid)`.
  - `prio` toggles to the other type whenever a transaction is accepted. Its reset value is RD.
- On acceptance, latch id, addr, len, size, burst; clear beat counter `cnt`.
  - AR accepted → RD.
  - AW accepted → WR.
- Address sequence per beat:
  - FIXED: address unchanged.
  - INCR: `(addr & ~((1<<size)-1)) + (1<<size)`, modulo 2^32. No 4 KB check.
  - WRAP: `mask = ((len+1)<<size)-1`; next = `(addr & ~mask) | ((addr + (1<<size)) & mask)`. len values other than 1/3/7/15 are treated as INCR.
  - burst 2'b11 is treated as INCR.
- Range check is per beat: in-window iff `addr[31:MEM_AW+3] == BASE[31:MEM_AW+3]`.
  - In window: resp 2'b00.
  - Out of window: resp 2'b11, no SRAM access, read data 0.
- `mem_addr = addr[MEM_AW+2:3]`. Narrow sizes access the full word; lane selection is the master's job via `wstrb` and address.
- RD:
  - Beat 0 is issued the cycle after AR acceptance.
  - Each later beat is issued in the cycle its predecessor handshakes (`S_rvalid && S_rready && !S_rlast`).
  - `S_rvalid` asserts the cycle after issue and holds until `S_rready`.
  - `S_rdata = err ? 0 : mem_rdata`; `S_rlast = (cnt==len)`; `S_rid` = latched id.
  - After the last handshake → IDLE.
- WR:
  - `S_wready = 1`.
  - Each W handshake drives, combinationally in that cycle: `mem_en=1`, `mem_we = err ? 0 : S_wstrb`, `mem_wdata = S_wdata`.
  - The beat with `cnt==len` moves to WRESP. `S_wlast` is ignored.
  - The error flag is sticky across the burst.
- WRESP:
  - `S_bvalid=1`, `S_bid` = latched id, `S_bresp` = 2'b11 if any beat erred, else 2'b00.
  - On `S_bready` → IDLE.

## Timing
- Reset values (with `reset` low, asynchronously):
  - State IDLE, `prio`=RD.
  - `S_rvalid`, `S_bvalid`, `S_wready`, `mem_en`, `mem_we` all 0.
  - `S_arready`/`S_awready` follow the IDLE equations.
- Read latency:
  - AR handshake at cycle T → `mem_en` at T+1 → `S_rvalid` at T+2.
  - With `S_rready` held high, one beat per cycle thereafter.
- Write: AW handshake at T → `S_wready` from T+1.
  - With `S_wvalid` held high, one beat per cycle.
  - `S_bvalid` comes the cycle after the final beat.
- A new AR/AW is accepted no earlier than the cycle after the last R or B handshake.
- Backpressure: `S_rready` low freezes `S_rdata`, `cnt` and the address, and issues no `mem_en`. Same for W with `S_wvalid` low.
- Simultaneous `S_arvalid` and `S_awvalid` in IDLE: exactly one ready is asserted, per `prio`.
- Reset mid-burst: the burst is dropped, no response is issued, and `cnt` is cleared.

## Test plan
- Single read:
  - Stimulus: SRAM word 0 = 64'h1122_3344_5566_7788; AR addr 0x8000_0000, len 0, size 3, id 5.
  - Required: `mem_en` at T+1; `S_rvalid` at T+2 with that data, rid 5, rresp 0, rlast 1.
- INCR write then read-back:
  - Stimulus: AW addr 0x8000_0100, len 3, size 3; wdata 1..4; strb 8'hFF then 8'h0F.
  - Required: `mem_addr` 0x20..0x23; bresp 0; read-back returns the written words, with the upper 4 bytes preserved on the partially strobed beats.
- WRAP read:
  - Stimulus: addr 0x8000_0018, len 3, size 3.
  - Required: `mem_addr` sequence 3, 0, 1, 2; rlast on beat 3 only.
- Out-of-window:
  - Stimulus: write to 0x0000_0000, len 1.
  - Required: `mem_we` 0 on both beats; bresp 2'b11.
  - Stimulus: read from 0x0000_0000.
  - Required: rdata 0, rresp 2'b11.
- Arbitration and backpressure:
  - Stimulus: AR and AW both valid in the same cycle after reset.
  - Required: read granted first, write next.
  - Stimulus: `S_rready` toggled 1/0 during a len 7 read.
  - Required: data held stable while stalled; 8 beats delivered in order.
- Reset mid-burst:
  - Stimulus: assert `reset` during beat 2 of a len 7 read.
  - Required: `S_rvalid` drops immediately; a new AR is accepted after reset release.
